dmem_lsu: RTL

//  Load/store unit between the CPU datapath and the byte-addressed, big-endian DMEM.

---
 rtl/dmem_lsu_if.sv | 35 +++
 rtl/dmem_lsu.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_if.sv
// Request/response and DMEM pin bundle for the load/store unit.
// The slave modport is the LSU side; the master modport is the CPU/DMEM side.
interface dmem_lsu_if;
   // Handshake: a request transfers on a rising edge where req_valid && req_ready;
   // resp_valid is a single-cycle pulse with no back-pressure.
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        dm_cs;
   logic        dm_w;
   logic        dm_r;
   logic [2:0]  dm_select;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dm_rdata,
      output req_ready, resp_valid, resp_err, resp_rdata,
      output dm_cs, dm_w, dm_r, dm_select, dm_addr, dm_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dm_rdata,
      input  req_ready, resp_valid, resp_err, resp_rdata,
      input  dm_cs, dm_w, dm_r, dm_select, dm_addr, dm_wdata
   );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: checks alignment/range, drives one registered DMEM access cycle,
// and returns an extended load result or an error pulse.
module dmem_lsu #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MEM_BYTES = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   dmem_lsu_if.slave   bus,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   logic [1:0]  state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        dm_cs_q, dm_cs_d;
   logic        dm_w_q, dm_w_d;
   logic        dm_r_q, dm_r_d;
   logic [2:0]  dm_select_q, dm_select_d;
   logic [31:0] dm_addr_q, dm_addr_d;
   logic [31:0] dm_wdata_q, dm_wdata_d;

   logic [31:0] off;
   logic        req_err;
   logic [31:0] load_data;

   always_comb begin
      off     = bus.req_addr - BASE_ADDR;
      req_err = (bus.req_size == 2'b11)
              | ((bus.req_size == 2'b01) & bus.req_addr[0])
              | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00))
              | (off >= 32'(MEM_BYTES));
   end

   // DMEM places the byte at the access offset in [31:24] (big-endian).
   always_comb begin
      load_data = bus.dm_rdata;
      case (size_q)
         2'b00:   load_data = uns_q ? {24'b0, bus.dm_rdata[31:24]}
                                    : {{24{bus.dm_rdata[31]}}, bus.dm_rdata[31:24]};
         2'b01:   load_data = uns_q ? {16'b0, bus.dm_rdata[31:16]}
                                    : {{16{bus.dm_rdata[31]}}, bus.dm_rdata[31:16]};
         default: load_data = bus.dm_rdata;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      uns_d        = uns_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'h0;
      dm_cs_d      = 1'b0;
      dm_w_d       = 1'b0;
      dm_r_d       = 1'b0;
      dm_select_d  = 3'b000;
      dm_addr_d    = 32'h0;
      dm_wdata_d   = 32'h0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               we_d   = bus.req_we;
               size_d = bus.req_size;
               uns_d  = bus.req_unsigned;
               if (req_err) begin
                  // Error skips DMEM entirely; the response follows in the next cycle.
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  state_d   = ST_ACCESS;
                  dm_cs_d   = 1'b1;
                  dm_w_d    = bus.req_we;
                  dm_r_d    = ~bus.req_we;
                  dm_addr_d = off;
                  case (bus.req_size)
                     2'b00: begin
                        dm_select_d = 3'b001;
                        dm_wdata_d  = {24'b0, bus.req_wdata[7:0]};
                     end
                     2'b01: begin
                        dm_select_d = 3'b010;
                        dm_wdata_d  = {16'b0, bus.req_wdata[15:0]};
                     end
                     default: begin
                        dm_select_d = 3'b100;
                        dm_wdata_d  = bus.req_wdata;
                     end
                  endcase
               end
            end
         end
         ST_ACCESS: begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            if (!we_q) resp_rdata_d = load_data;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
         dm_cs_q      <= 1'b0;
         dm_w_q       <= 1'b0;
         dm_r_q       <= 1'b0;
         dm_select_q  <= 3'b000;
         dm_addr_q    <= 32'h0;
         dm_wdata_q   <= 32'h0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         dm_cs_q      <= dm_cs_d;
         dm_w_q       <= dm_w_d;
         dm_r_q       <= dm_r_d;
         dm_select_q  <= dm_select_d;
         dm_addr_q    <= dm_addr_d;
         dm_wdata_q   <= dm_wdata_d;
      end
   end

   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.dm_cs      = dm_cs_q;
   assign bus.dm_w       = dm_w_q;
   assign bus.dm_r       = dm_r_q;
   assign bus.dm_select  = dm_select_q;
   assign bus.dm_addr    = dm_addr_q;
   assign bus.dm_wdata   = dm_wdata_q;
   assign dbg_state      = state_q;

endmodule
